// File: rtl/key_search_pkg.sv
// Shared types for the RC4 key-search dispatcher: FSM states, chunk bounds and the chunk helper.
package key_search_pkg;

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

   // Wide enough that base + chunk span never wraps for any supported KEY_W (< 64).
   localparam int KS_MAX_W = 64;
   typedef logic [KS_MAX_W-1:0] ks_key_t;

   typedef struct packed {
      ks_key_t first;
      ks_key_t last;
   } chunk_t;

   function automatic chunk_t chunk_calc(input ks_key_t base, input ks_key_t hi, input int unsigned clog);
      chunk_t  c;
      ks_key_t top;
      top     = base + ((ks_key_t'(1) << clog) - ks_key_t'(1));
      c.first = base;
      c.last  = (top > hi) ? hi : top;
      return c;
   endfunction

endpackage

// File: rtl/key_search_dispatcher_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, priority rotates past the last winner.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [N-1:0] gnt_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0]  ptr_q, ptr_d, win;
   logic [PW:0]    off, sum;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic           hit;

   // Rotate so the pointer position sits at bit 0, pick the first set bit, then rotate back.
   always_comb begin
      dbl   = {req_i, req_i} >> ptr_q;
      rot   = en_i ? dbl[N-1:0] : '0;
      hit   = 1'b0;
      off   = '0;
      for (int i = 0; i < N; i++) begin
         if (!hit && rot[i]) begin
            hit = 1'b1;
            off = (PW+1)'(i);
         end
      end
      sum = {1'b0, ptr_q} + off;
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      win   = sum[PW-1:0];
      gnt_o = '0;
      if (hit) gnt_o[win] = 1'b1;
      ptr_d = (win == PW'(N-1)) ? '0 : win + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)    ptr_q <= '0;
      else if (hit) ptr_q <= ptr_d;
   end

endmodule

// File: rtl/key_search_dispatcher.sv
// Dynamic chunk dispatcher for the RC4 key-search core array.
// Optional KEY_SEARCH_PROGRESS_EN adds keys_done / cycles progress counters.
module key_search_dispatcher
   import key_search_pkg::*;
#(
   parameter int NUM_CORES     = 51,
   parameter int LOG_NUM_CORES = 8,
   parameter int KEY_W         = 24,
   parameter int CHUNK_LOG     = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [KEY_W-1:0]           key_lo,
   input  logic [KEY_W-1:0]           key_hi,
   input  logic [NUM_CORES-1:0]       core_req,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES-1:0]       core_found,
   input  logic [NUM_CORES*KEY_W-1:0] core_key,
   output logic [NUM_CORES-1:0]       core_grant,
   output logic [KEY_W-1:0]           chunk_first,
   output logic [KEY_W-1:0]           chunk_last,
   output logic                       core_kill,
   output logic                       busy,
   output logic                       finished,
   output logic                       success,
   output logic [KEY_W-1:0]           found_key,
   output logic [LOG_NUM_CORES-1:0]   found_core
`ifdef KEY_SEARCH_PROGRESS_EN
   ,
   output logic [KEY_W:0]             keys_done,
   output logic [31:0]                cycles
`endif
);

   state_t                   state_q, state_d;
   logic [NUM_CORES-1:0]     mask_q, mask_d, grant_q, arb_gnt, elig, hit_v;
   logic [KEY_W-1:0]         base_q, hi_q, first_q, last_q, fkey_q, hit_key, next_last;
   logic [LOG_NUM_CORES-1:0] fcore_q, hit_idx;
   logic                     kill_q, success_q, any_hit, start_ok, in_search, stop, arb_en, exhaust;
   chunk_t                   ch;
   logic                     unused_chunk_hi;

   assign in_search = (state_q == DISPATCH) || (state_q == DRAIN);
   assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
   assign hit_v     = core_done & core_found & mask_q;
   assign any_hit   = |hit_v;
   assign stop      = in_search && (any_hit || abort);
   assign arb_en    = (state_q == DISPATCH) && !any_hit && !abort;
   assign elig      = core_req & ~mask_q & ~grant_q;

   assign ch              = chunk_calc(ks_key_t'(base_q), ks_key_t'(hi_q), unsigned'(CHUNK_LOG));
   assign next_last       = ch.last[KEY_W-1:0];
   assign exhaust         = (|arb_gnt) && (next_last == hi_q);
   assign unused_chunk_hi = ^{ch.first[KS_MAX_W-1:KEY_W], ch.last[KS_MAX_W-1:KEY_W]};

   rr_arbiter #(.N(NUM_CORES)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req_i (elig),
      .en_i  (arb_en),
      .gnt_o (arb_gnt)
   );

   // Descending scan leaves the lowest-index finder as the winner.
   always_comb begin
      hit_idx = '0;
      hit_key = '0;
      for (int i = NUM_CORES-1; i >= 0; i--) begin
         if (hit_v[i]) begin
            hit_idx = LOG_NUM_CORES'(i);
            hit_key = core_key[i*KEY_W +: KEY_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = (key_hi < key_lo) ? DONE : DISPATCH;
         DISPATCH: begin
            if (any_hit || abort) state_d = DONE;
            else if (exhaust)     state_d = DRAIN;
         end
         DRAIN: if (any_hit || abort || (mask_q == '0)) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = in_search;
      finished = (state_q == DONE);
   end

   always_comb begin
      if (start_ok || stop) mask_d = '0;
      else                  mask_d = (mask_q & ~core_done) | arb_gnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q    <= '0;
         grant_q   <= '0;
         kill_q    <= 1'b0;
         base_q    <= '0;
         hi_q      <= '0;
         first_q   <= '0;
         last_q    <= '0;
         success_q <= 1'b0;
         fkey_q    <= '0;
         fcore_q   <= '0;
      end else begin
         mask_q  <= mask_d;
         grant_q <= arb_gnt;
         kill_q  <= stop;
         if (start_ok) begin
            base_q    <= key_lo;
            hi_q      <= key_hi;
            success_q <= 1'b0;
            fkey_q    <= '0;
            fcore_q   <= '0;
         end else if (|arb_gnt) begin
            first_q <= ch.first[KEY_W-1:0];
            last_q  <= next_last;
            base_q  <= next_last + KEY_W'(1);
         end
         if (in_search && any_hit) begin
            success_q <= 1'b1;
            fkey_q    <= hit_key;
            fcore_q   <= hit_idx;
         end
      end
   end

   assign core_grant  = grant_q;
   assign chunk_first = first_q;
   assign chunk_last  = last_q;
   assign core_kill   = kill_q;
   assign success     = success_q;
   assign found_key   = fkey_q;
   assign found_core  = fcore_q;

`ifdef KEY_SEARCH_PROGRESS_EN
   logic [NUM_CORES-1:0][CHUNK_LOG:0] sz_q;
   logic [KEY_W:0]                    kd_q, kd_sum;
   logic [31:0]                       cyc_q;

   // Each core remembers the size of its outstanding chunk so completions can be summed.
   always_comb begin
      kd_sum = kd_q;
      for (int i = 0; i < NUM_CORES; i++)
         if (core_done[i] && mask_q[i]) kd_sum = kd_sum + (KEY_W+1)'(sz_q[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sz_q  <= '0;
         kd_q  <= '0;
         cyc_q <= '0;
      end else begin
         if (start_ok) begin
            kd_q  <= '0;
            cyc_q <= '0;
         end else begin
            kd_q <= kd_sum;
            if (in_search && (cyc_q != '1)) cyc_q <= cyc_q + 32'd1;
         end
         for (int i = 0; i < NUM_CORES; i++)
            if (arb_gnt[i]) sz_q[i] <= (CHUNK_LOG+1)'(next_last - base_q) + 1'b1;
      end
   end

   assign keys_done = kd_q;
   assign cycles    = cyc_q;
`else
   // Progress counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Scoreboard bench for key_search_dispatcher: 4 cores, 24-bit keys, 4K-key chunks.
module tb_key_search_dispatcher;

   localparam int NC = 4;
   localparam int KW = 24;

   typedef struct {
      logic [NC-1:0] gnt;
      logic [KW-1:0] first;
      logic [KW-1:0] last;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset, start, abort;
   logic [KW-1:0]    key_lo, key_hi;
   logic [NC-1:0]    core_req, core_done, core_found;
   logic [NC*KW-1:0] core_key;
   logic [NC-1:0]    core_grant;
   logic [KW-1:0]    chunk_first, chunk_last, found_key;
   logic             core_kill, busy, finished, success;
   logic [7:0]       found_core;
`ifdef KEY_SEARCH_PROGRESS_EN
   logic [KW:0]      keys_done;
   logic [31:0]      cycles;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_gnt   = 0;
   int   n_kill  = 0;
   int   cyc     = 0;
   exp_t exp_q[$];
   int   gcyc_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   key_search_dispatcher #(.NUM_CORES(NC), .LOG_NUM_CORES(8), .KEY_W(KW), .CHUNK_LOG(12)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .key_lo(key_lo), .key_hi(key_hi),
      .core_req(core_req), .core_done(core_done), .core_found(core_found), .core_key(core_key),
      .core_grant(core_grant), .chunk_first(chunk_first), .chunk_last(chunk_last),
      .core_kill(core_kill), .busy(busy), .finished(finished), .success(success),
      .found_key(found_key), .found_core(found_core)
`ifdef KEY_SEARCH_PROGRESS_EN
      , .keys_done(keys_done), .cycles(cycles)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Grant monitor: every grant must match the next expected chunk in order.
   always @(negedge clk) begin
      exp_t e;
      if (core_kill) n_kill++;
      if (core_grant != '0) begin
         n_gnt++;
         gcyc_q.push_back(cyc);
         if (exp_q.size() == 0) chk("extra_grant", 64'(core_grant), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("grant_vec",   64'(core_grant),  64'(e.gnt));
            chk("chunk_first", 64'(chunk_first), 64'(e.first));
            chk("chunk_last",  64'(chunk_last),  64'(e.last));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic go(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
      key_lo = lo;
      key_hi = hi;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // Reference chunking: consecutive 4K windows clipped at hi, cores rotating by step.
   task automatic push_range(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input int n, input int step);
      logic [KW:0] base, last;
      exp_t        e;
      base = {1'b0, lo};
      for (int k = 0; k < n; k++) begin
         last = base + 25'h000FFF;
         if (last > {1'b0, hi}) last = {1'b0, hi};
         e.gnt   = 4'b0001 << ((k * step) % NC);
         e.first = base[KW-1:0];
         e.last  = last[KW-1:0];
         exp_q.push_back(e);
         base = last + 25'd1;
      end
   endtask

   // Core model: a granted core drops req, reports done (not found) after lat cycles, then re-requests.
   task automatic serve(input int max_cyc, input int lat, input logic [NC-1:0] rm);
      int cnt[NC];
      for (int i = 0; i < NC; i++) cnt[i] = 0;
      for (int c = 0; c < max_cyc; c++) begin
         tick();
         core_done = '0;
         for (int i = 0; i < NC; i++) begin
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) begin
                  core_done[i] = 1'b1;
                  core_req[i]  = rm[i];
               end
            end
            if (core_grant[i]) begin
               core_req[i] = 1'b0;
               cnt[i]      = lat;
            end
         end
         if (finished) break;
      end
      core_done = '0;
   endtask

   initial begin
      int g0, k0, q0;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      key_lo = '0; key_hi = '0;
      core_req = '0; core_done = '0; core_found = '0; core_key = '0;
      tick();
      tick();
      chk("rst_bus",  64'({core_grant, chunk_first, chunk_last}), 64'd0);
      chk("rst_flag", 64'({core_kill, busy, finished, success, found_key, found_core}), 64'd0);
      reset = 1'b0;

      // Single requesting core, three chunks, no find.
      do_reset();
      g0 = n_gnt; k0 = n_kill;
      push_range(24'h000000, 24'h002FFF, 3, 0);
      core_req = 4'b0001;
      go(24'h000000, 24'h002FFF);
      chk("s1_busy", 64'(busy), 64'd1);
      serve(300, 3, 4'b0001);
      chk("s1_finished", 64'(finished), 64'd1);
      chk("s1_success",  64'(success),  64'd0);
      chk("s1_ngrant",   64'(n_gnt - g0), 64'd3);
      chk("s1_nokill",   64'(n_kill - k0), 64'd0);
      chk("s1_sb_empty", 64'(exp_q.size()), 64'd0);

      // Four cores all requesting: grants 0,1,2,3 back to back.
      do_reset();
      g0 = n_gnt; q0 = gcyc_q.size();
      push_range(24'h000000, 24'h003FFF, 4, 1);
      core_req = 4'b1111;
      go(24'h000000, 24'h003FFF);
      serve(300, 10, 4'b1111);
      chk("s2_ngrant",   64'(n_gnt - g0), 64'd4);
      if (gcyc_q.size() >= q0 + 4) chk("s2_consec", 64'(gcyc_q[q0+3] - gcyc_q[q0]), 64'd3);
      else                         chk("s2_consec", 64'(gcyc_q.size() - q0), 64'd4);
      chk("s2_finished", 64'(finished), 64'd1);
      chk("s2_success",  64'(success),  64'd0);
      chk("s2_sb_empty", 64'(exp_q.size()), 64'd0);

      // Core 2 reports the key; kill pulses once, grants stop.
      do_reset();
      k0 = n_kill;
      push_range(24'h000000, 24'h00FFFF, 4, 1);
      core_req = 4'b1111;
      go(24'h000000, 24'h00FFFF);
      serve(8, 1000, 4'b1111);
      core_done = 4'b0100; core_found = 4'b0100; core_key[2*KW +: KW] = 24'h0012AB;
      tick();
      core_done = '0; core_found = '0;
      chk("s3_kill",     64'(core_kill),  64'd1);
      chk("s3_finished", 64'(finished),   64'd1);
      chk("s3_success",  64'(success),    64'd1);
      chk("s3_key",      64'(found_key),  64'h0012AB);
      chk("s3_core",     64'(found_core), 64'd2);
      core_req = 4'b1111;
      for (int i = 0; i < 6; i++) tick();
      chk("s3_kill_once", 64'(n_kill - k0), 64'd1);
      chk("s3_sb_empty",  64'(exp_q.size()), 64'd0);
      chk("s3_idle_bus",  64'(busy), 64'd0);

      // Cores 1 and 3 find together with abort: lowest index wins, find beats abort.
      do_reset();
      push_range(24'h000000, 24'h00FFFF, 4, 1);
      core_req = 4'b1111;
      go(24'h000000, 24'h00FFFF);
      serve(8, 1000, 4'b1111);
      core_done = 4'b1010; core_found = 4'b1010; abort = 1'b1;
      core_key[1*KW +: KW] = 24'h001111;
      core_key[3*KW +: KW] = 24'h003333;
      tick();
      core_done = '0; core_found = '0; abort = 1'b0;
      chk("s4_core",     64'(found_core), 64'd1);
      chk("s4_key",      64'(found_key),  64'h001111);
      chk("s4_success",  64'(success),    64'd1);
      chk("s4_sb_empty", 64'(exp_q.size()), 64'd0);

      // Restart from DONE at the top of the key space: one chunk, no wrap.
      g0 = n_gnt;
      push_range(24'hFFF000, 24'hFFFFFF, 1, 0);
      core_req = 4'b0001;
      go(24'hFFF000, 24'hFFFFFF);
      chk("s5_cleared", 64'({finished, success, found_key}), 64'd0);
      serve(300, 3, 4'b0001);
      chk("s5_ngrant",   64'(n_gnt - g0), 64'd1);
      chk("s5_finished", 64'(finished), 64'd1);
      chk("s5_success",  64'(success),  64'd0);
      chk("s5_sb_empty", 64'(exp_q.size()), 64'd0);

      // Inverted range: DONE next cycle, no grant; a stray done is ignored.
      do_reset();
      core_req = 4'b0001;
      go(24'h000100, 24'h000050);
      chk("s6_done",    64'({finished, busy, success}), 64'b100);
      core_done = 4'b0001; core_found = 4'b0001; core_key[0 +: KW] = 24'h0000AA;
      tick();
      core_done = '0; core_found = '0;
      tick();
      chk("s6_ignored", 64'({success, found_key}), 64'd0);

      // Reset mid-dispatch: everything returns to zero.
      do_reset();
      push_range(24'h000000, 24'h00FFFF, 1, 1);
      core_req = 4'b1111;
      go(24'h000000, 24'h00FFFF);
      tick();
      reset = 1'b1;
      tick();
      chk("s7_bus",  64'({core_grant, chunk_first, chunk_last}), 64'd0);
      chk("s7_flag", 64'({core_kill, busy, finished, success, found_key, found_core}), 64'd0);
      reset = 1'b0;
      core_req = '0;
      tick();
      chk("s7_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
